// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit bridging a single-request port to a word-wide memory
// Handles byte/half/word access with lane steering, extension and range/alignment errors.
module lsu #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int          MEM_WORDS = 65536
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    output logic [31:0] mem_raddr,
    output logic        mem_ren,
    input  logic [31:0] mem_rdata,

    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_wen
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // One past the last valid byte; 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  lat_lane;
    logic [1:0]  lat_size;
    logic        lat_unsigned;

    logic [29:0] word_idx;
    logic        in_range;
    logic        req_err;
    logic        accept;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    assign word_idx = 30'((req_addr - MEM_BASE) >> 2);
    assign in_range = ({1'b0, req_addr} >= {1'b0, MEM_BASE}) && ({1'b0, req_addr} < MEM_END);

    always_comb begin
        req_err = !in_range;
        case (req_size)
            SZ_HALF: if (req_addr[0])             req_err = 1'b1;
            SZ_WORD: if (req_addr[1:0] != 2'b00)  req_err = 1'b1;
            SZ_BYTE: ;
            default:                              req_err = 1'b1;
        endcase
    end

    // Gated by rst_n so the memory sees no strobes while reset is held.
    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_ready && req_valid;
    assign mem_ren   = accept && !req_err && !req_wen;
    assign mem_wen   = accept && !req_err && req_wen;
    assign mem_raddr = {2'b00, word_idx};
    assign mem_waddr = {2'b00, word_idx};

    always_comb begin
        mem_wdata = req_wdata;
        mem_wmask = 4'b0000;
        case (req_size)
            SZ_BYTE: begin
                mem_wdata = {4{req_wdata[7:0]}};
                mem_wmask = 4'b0001 << req_addr[1:0];
            end
            SZ_HALF: begin
                mem_wdata = {2{req_wdata[15:0]}};
                mem_wmask = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                mem_wdata = req_wdata;
                mem_wmask = 4'b1111;
            end
        endcase
        if (!mem_wen)
            mem_wmask = 4'b0000;
    end

    always_comb begin
        load_byte = mem_rdata[8*lat_lane +: 8];
        load_half = mem_rdata[16*lat_lane[1] +: 16];
        case (lat_size)
            SZ_BYTE: load_ext = {{24{load_byte[7] & ~lat_unsigned}}, load_byte};
            SZ_HALF: load_ext = {{16{load_half[15] & ~lat_unsigned}}, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            lat_lane     <= 2'b00;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_err || req_wen) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            resp_err   <= req_err;
                        end else begin
                            state        <= RD_WAIT;
                            lat_lane     <= req_addr[1:0];
                            lat_size     <= req_size;
                            lat_unsigned <= req_unsigned;
                        end
                    end
                end
                RD_WAIT: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_ext;
                    resp_err   <= 1'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_raddr;
    logic        mem_ren;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wen;

    int errors = 0;
    int checks = 0;

    logic [31:0] tb_mem [0:15];

    always #5 clk = ~clk;

    lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_raddr    (mem_raddr),
        .mem_ren      (mem_ren),
        .mem_rdata    (mem_rdata),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_wen      (mem_wen)
    );

    // Small backing store: read data valid the cycle after mem_ren, masked byte writes.
    always @(posedge clk) begin
        if (mem_ren)
            mem_rdata <= tb_mem[mem_raddr[3:0]];
        if (mem_wen)
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b])
                    tb_mem[mem_waddr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        #1;
    endtask

    task automatic accept();
        tick();
        req_valid = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] exp_idx, input logic [31:0] exp);
        issue(1'b0, addr, size, uns, 32'h0);
        chk({tag, "_ren"}, mem_ren, 1);
        chk({tag, "_raddr"}, mem_raddr, exp_idx);
        accept();
        chk({tag, "_early"}, resp_valid, 0);
        tick();
        chk({tag, "_valid"}, resp_valid, 1);
        chk({tag, "_rdata"}, resp_rdata, exp);
        chk({tag, "_err"}, resp_err, 0);
        tick();
    endtask

    task automatic err_chk(input string tag, input logic wen, input logic [31:0] addr,
                           input logic [1:0] size);
        issue(wen, addr, size, 1'b0, 32'h1234_5678);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_noacc"}, {mem_ren, mem_wen}, 0);
        accept();
        chk({tag, "_valid"}, resp_valid, 1);
        chk({tag, "_err"}, resp_err, 1);
        chk({tag, "_rdata"}, resp_rdata, 0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tb_mem[i] = 32'h0;
        tb_mem[8]    = 32'h80FF_7F01;
        rst_n        = 1'b0;
        resp_ready   = 1'b1;
        req_valid    = 1'b1;
        req_wen      = 1'b1;
        req_addr     = 32'h8000_0010;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;

        // Reset holds everything quiet even with a legal request presented.
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_mem", {mem_ren, mem_wen}, 0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("idle_ready", req_ready, 1);

        // Word store then load back.
        issue(1'b1, 32'h8000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF);
        chk("sw_wen", mem_wen, 1);
        chk("sw_ren", mem_ren, 0);
        chk("sw_waddr", mem_waddr, 4);
        chk("sw_mask", mem_wmask, 4'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        accept();
        chk("sw_valid", resp_valid, 1);
        chk("sw_rdata", resp_rdata, 0);
        chk("sw_err", resp_err, 0);
        tick();
        chk("sw_back_idle", resp_valid, 0);
        load_chk("lw", 32'h8000_0010, 2'b10, 1'b0, 4, 32'hDEAD_BEEF);

        // Extension from word 0x80FF_7F01.
        load_chk("lb_s3", 32'h8000_0023, 2'b00, 1'b0, 8, 32'hFFFF_FF80);
        load_chk("lbu_3", 32'h8000_0023, 2'b00, 1'b1, 8, 32'h0000_0080);
        load_chk("lh_s2", 32'h8000_0022, 2'b01, 1'b0, 8, 32'hFFFF_80FF);
        load_chk("lhu_0", 32'h8000_0020, 2'b01, 1'b1, 8, 32'h0000_7F01);
        load_chk("lb_s1", 32'h8000_0021, 2'b00, 1'b0, 8, 32'h0000_007F);

        // Byte and half stores, then read the merged words back.
        issue(1'b1, 32'h8000_0001, 2'b00, 1'b0, 32'h0000_00AB);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_mask", mem_wmask, 4'b0010);
        chk("sb_waddr", mem_waddr, 0);
        accept();
        chk("sb_valid", resp_valid, 1);
        chk("sb_rdata", resp_rdata, 0);
        tick();
        issue(1'b1, 32'h8000_0006, 2'b01, 1'b0, 32'hFFFF_1234);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        chk("sh_mask", mem_wmask, 4'b1100);
        chk("sh_waddr", mem_waddr, 1);
        accept();
        chk("sh_valid", resp_valid, 1);
        tick();
        load_chk("lw_sb", 32'h8000_0000, 2'b10, 1'b0, 0, 32'h0000_AB00);
        load_chk("lw_sh", 32'h8000_0004, 2'b10, 1'b0, 1, 32'h1234_0000);

        // Error cases and range boundaries.
        err_chk("e_half_mis", 1'b0, 32'h8000_0003, 2'b01);
        err_chk("e_below", 1'b0, 32'h7FFF_FFFC, 2'b10);
        err_chk("e_word_mis", 1'b1, 32'h8000_0002, 2'b10);
        err_chk("e_size11", 1'b0, 32'h8000_0000, 2'b11);
        err_chk("e_above", 1'b1, 32'h8004_0000, 2'b00);
        load_chk("l_top", 32'h8003_FFFC, 2'b10, 1'b0, 32'h0000_FFFF, 32'h0);

        // Back-pressure: response held, new request ignored.
        resp_ready = 1'b0;
        issue(1'b0, 32'h8000_0023, 2'b00, 1'b1, 32'h0);
        accept();
        tick();
        issue(1'b1, 32'h8000_0000, 2'b10, 1'b0, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_rdata", resp_rdata, 32'h0000_0080);
            chk("bp_ready", req_ready, 0);
            chk("bp_mem", {mem_ren, mem_wen}, 0);
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("bp_release", resp_valid, 0);
        chk("bp_mem_kept", tb_mem[0], 32'h0000_AB00);

        // Reset in RD_WAIT discards the load.
        issue(1'b0, 32'h8000_0020, 2'b00, 1'b0, 32'h0);
        accept();
        chk("rw_pending", resp_valid, 0);
        rst_n     = 1'b0;
        req_valid = 1'b1;
        #1;
        chk("ar_valid", resp_valid, 0);
        chk("ar_rdata", resp_rdata, 0);
        chk("ar_err", resp_err, 0);
        chk("ar_ready", req_ready, 0);
        chk("ar_mem", {mem_ren, mem_wen}, 0);
        tick();
        req_valid = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_no_resp", resp_valid, 0);
        end
        issue(1'b1, 32'h8000_0002, 2'b00, 1'b0, 32'h0000_00CD);
        chk("post_ready", req_ready, 1);
        chk("post_mask", mem_wmask, 4'b0100);
        accept();
        chk("post_valid", resp_valid, 1);
        chk("post_err", resp_err, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h8000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 65536, number of 32-bit memory words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-007 SHALL have port req_wen, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned, input, 1, load zero-extend when 1, sign-extend when 0.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1, response present.
REQ-013 SHALL have port resp_ready, input, 1, response consumed when high with resp_valid.
REQ-014 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1, misaligned, illegal size or out-of-range access.
REQ-016 SHALL have ports mem_raddr (output, 32, word index), mem_ren (output, 1), and mem_rdata (input, 32, valid the cycle after mem_ren).
REQ-017 SHALL have ports mem_waddr (output, 32, word index), mem_wdata (output, 32), mem_wmask (output, 4, bit n enables byte n), and mem_wen (output, 1).

Function
REQ-018 SHALL implement FSM states IDLE, RD_WAIT and RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL compute the word index as (req_addr - MEM_BASE) >> 2 and drive it on mem_raddr and mem_waddr.
REQ-020 SHALL flag an error when the size is 11, when size=01 and addr[0]=1, when size=10 and addr[1:0]!=0, or when addr < MEM_BASE or addr >= MEM_BASE + 4*MEM_WORDS.
REQ-021 SHALL drive mem_ren and mem_wen combinationally, and only in the acceptance cycle (IDLE, req_valid=1, no error), as a load or store respectively; both are 0 otherwise.
REQ-022 SHALL drive stores as follows, with lane = addr[1:0]:
  - byte: mem_wdata = {4{wdata[7:0]}}, mem_wmask = 0001 << lane.
  - half: mem_wdata = {2{wdata[15:0]}}, mem_wmask = 0011 << (2*addr[1]).
  - word: mem_wdata = wdata, mem_wmask = 1111.
REQ-023 SHALL move IDLE -> RD_WAIT on an accepted legal load, latching lane, size and req_unsigned.
REQ-024 SHALL, in RD_WAIT, extract mem_rdata[8*lane+:8] for byte loads or mem_rdata[16*addr[1]+:16] for half loads, extend per req_unsigned, register the result into resp_rdata, and go to RESP.
REQ-025 SHALL move IDLE -> RESP on an accepted legal store (resp_rdata=0, resp_err=0) or on any accepted erroneous request (resp_rdata=0, resp_err=1); an erroneous request makes no memory access.
REQ-026 SHALL assert resp_valid only in RESP, hold resp_rdata and resp_err stable there, and go RESP -> IDLE when resp_ready=1.
REQ-027 SHALL give these latencies from acceptance edge to resp_valid: load 2 cycles; store or error 1 cycle.
REQ-028 SHALL ignore req_valid outside IDLE; requests are never queued.

Reset
REQ-029 SHALL, on rst_n low, immediately set state IDLE, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-030 SHALL force req_ready, mem_ren and mem_wen to 0 while rst_n is low.
REQ-031 SHALL silently discard any in-flight load or pending response on reset; after release it accepts on the first edge.

Verification
REQ-032 Store word 0xDEADBEEF at 0x8000_0010, then load word -> mem_waddr=4, mask=1111; load resp_rdata=0xDEADBEEF two cycles after acceptance, resp_err=0.
REQ-033 mem word 0x80FF_7F01; load byte signed at offset 3 -> 0xFFFF_FF80; unsigned -> 0x0000_0080; signed half at offset 2 -> 0xFFFF_80FF.
REQ-034 Store byte 0xAB at 0x8000_0001 -> mem_wdata=0xABAB_ABAB, mem_wmask=0010, resp 1 cycle later, resp_rdata=0.
REQ-035 Half load at 0x8000_0003 and word load at 0x7FFF_FFFC -> no mem_ren pulse, resp_err=1, resp_rdata=0.
REQ-036 Hold resp_ready=0 for 5 cycles while req_valid=1 -> resp_valid and resp_rdata stable, req_ready=0, no mem access.
REQ-037 Assert rst_n=0 in RD_WAIT -> outputs 0 asynchronously; after release no response emerges for the discarded load.
